wishbone_ram_slave: RTL and testbench
=====================================

// Module: wishbone_ram_slave
// PURPOSE
//  Wishbone B4 classic-cycle slave: word-addressed single-port RAM responding to the fetch and memory stages.
//  Serves as the instruction/data backing store in simulation and FPGA builds.
//  Sits at the responder end of wishbone_interface; wait states are configurable so master stall paths are exercised.
// PARAMETERS
//  DEPTH_WORDS  1024       number of 32-bit words; power of two, >= 4
//  BASE_ADDR    32'h0      byte address of word 0; aligned to DEPTH_WORDS*4
//  WAIT_STATES  1          idle cycles between request capture and ack/err; 0..15
//  INIT_FILE    ""         $readmemh image loaded at elaboration; empty = contents undefined
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     asynchronous reset, active-low (asserted when 0)
//  wb.cyc       in   1     bus cycle active
//  wb.stb       in   1     strobe / request valid
//  wb.we        in   1     1 = write, 0 = read
//  wb.adr       in   32    byte address
//  wb.sel       in   4     byte lane enables, sel[i] -> dat[8i+7:8i]
//  wb.dat_mosi  in   32    write data
//  wb.dat_miso  out  32    read data, valid with ack
//  wb.ack       out  1     normal termination, one-cycle pulse
//  wb.err       out  1     error termination, one-cycle pulse
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, wait counter=0, ack=0, err=0, dat_miso=32'h0. RAM contents not cleared.
//  - FSM IDLE -> WAIT -> RESP -> IDLE; all outputs registered.
//  - IDLE: cyc&stb high at edge -> capture adr, we, sel, dat_mosi; load counter=WAIT_STATES;
//    go WAIT (or RESP directly if WAIT_STATES==0).
//  - WAIT: decrement counter each cycle; at 0 go RESP. Captured request is used, not live bus values.
//  - RESP: exactly one of ack/err high for one cycle, then IDLE.
//    New request sampled in IDLE the following cycle: back-to-back throughput = WAIT_STATES+2 cycles/transfer.
//  - Latency: request edge to ack high = WAIT_STATES+1 cycles.
//  - Decode: off = adr - BASE_ADDR; error if adr[1:0]!=0 or off >= DEPTH_WORDS*4; else index = off[..:2].
//  - Error: err=1, ack=0, no RAM write, dat_miso=32'h0.
//  - Read: dat_miso = RAM[index] on the ack cycle; held until next response; sel ignored for reads.
//  - Write: commit at the RESP edge only, bytes where sel[i]=1; sel=4'b0000 is legal (ack, no change); dat_miso unchanged.
//  - Abort: cyc low during WAIT -> return to IDLE next edge, no ack/err, no write.
//  - cyc low or stb low in IDLE: no action. Request held after ack is treated as a new request.
//  - Reset mid-operation: pending write discarded, no ack/err; RAM unchanged.
// CONFIGURATION
//  WB_RAM_STALL_RANDOM_EN
//   defined: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) steps once per accepted request;
//     lfsr[1:0] (0..3) is added to the loaded wait count. Latency = WAIT_STATES+1+lfsr[1:0].
//   undefined: no LFSR logic; latency fixed at WAIT_STATES+1.
// TESTING
//  1 WAIT_STATES=1: write adr=0x10 dat=0xDEADBEEF sel=F, then read 0x10 -> ack 2 cycles after each request, dat_miso=0xDEADBEEF
//  2 preload 0x11223344 @0x20; write sel=4'b0010 dat=0x0000AA00; read -> 0x1122AA44
//  3 read adr=0x22 (misaligned) and adr=DEPTH_WORDS*4 -> err pulse 1 cycle, ack=0, dat_miso=0, RAM unchanged
//  4 write to 0x30 with cyc dropped during WAIT (WAIT_STATES=3) -> no ack/err; read 0x30 returns old value
//  5 rst=0 pulse during WAIT of write to 0x40 -> ack/err/dat_miso=0 immediately; 0x40 unchanged after reset
//  6 WAIT_STATES=0, 8 back-to-back reads -> one ack per 2 cycles; macro defined -> each latency in 1..4, order preserved

Source files
------------

// File: rtl/wishbone_ram_slave.sv
// Wishbone B4 classic slave: word-addressed single-port RAM with byte lanes, decode errors and abort support.
// Latency: request edge to ack/err is WAIT_STATES+1 cycles, plus 0..3 LFSR cycles when WB_RAM_STALL_RANDOM_EN is defined.
// Backpressure: no stall signal; requests are taken only in IDLE, so back-to-back throughput is WAIT_STATES+2 cycles.
module wishbone_ram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_mosi,
    output logic [31:0] wb_dat_miso,
    output logic        wb_ack,
    output logic        wb_err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    state;
    logic [4:0]    wait_cnt;
    logic          cap_we;
    logic          cap_bad;
    logic [3:0]    cap_sel;
    logic [31:0]   cap_dat;
    logic [AW-1:0] cap_idx;

    logic [31:0]   off;
    logic          req_bad;
    logic [AW-1:0] req_idx;
    logic [4:0]    load_cnt;
    logic          accept;

    logic          fire;
    logic          fire_we;
    logic          fire_bad;
    logic [3:0]    fire_sel;
    logic [31:0]   fire_dat;
    logic [AW-1:0] fire_idx;

    assign off     = wb_adr - BASE_ADDR;
    assign req_bad = (wb_adr[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
    assign req_idx = off[AW+1:2];
    assign accept  = (state == ST_IDLE) && wb_cyc && wb_stb;

`ifdef WB_RAM_STALL_RANDOM_EN
    logic [7:0] lfsr;

    assign load_cnt = 5'(WAIT_STATES) + {3'b000, lfsr[1:0]};

    // x^8+x^6+x^5+x^4+1, advanced once per accepted request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`else
    assign load_cnt = 5'(WAIT_STATES);
`endif

    // fire marks the edge that enters RESP; with zero wait the live bus is used directly
    always_comb begin
        fire     = 1'b0;
        fire_we  = cap_we;
        fire_bad = cap_bad;
        fire_sel = cap_sel;
        fire_dat = cap_dat;
        fire_idx = cap_idx;
        if (accept && (load_cnt == 5'd0)) begin
            fire     = 1'b1;
            fire_we  = wb_we;
            fire_bad = req_bad;
            fire_sel = wb_sel;
            fire_dat = wb_dat_mosi;
            fire_idx = req_idx;
        end else if ((state == ST_WAIT) && wb_cyc && (wait_cnt == 5'd1)) begin
            fire = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= 5'd0;
            wb_ack      <= 1'b0;
            wb_err      <= 1'b0;
            wb_dat_miso <= 32'h0;
            cap_we      <= 1'b0;
            cap_bad     <= 1'b0;
            cap_sel     <= 4'h0;
            cap_dat     <= 32'h0;
            cap_idx     <= '0;
        end else begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap_we   <= wb_we;
                        cap_bad  <= req_bad;
                        cap_sel  <= wb_sel;
                        cap_dat  <= wb_dat_mosi;
                        cap_idx  <= req_idx;
                        wait_cnt <= load_cnt;
                        state    <= (load_cnt == 5'd0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!wb_cyc) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 5'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 5'd1;
                        if (wait_cnt == 5'd1) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (fire) begin
                wb_ack <= !fire_bad;
                wb_err <= fire_bad;
                if (fire_bad) begin
                    wb_dat_miso <= 32'h0;
                end else if (!fire_we) begin
                    wb_dat_miso <= mem[fire_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire && fire_we && !fire_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (fire_sel[i]) begin
                    mem[fire_idx][8*i +: 8] <= fire_dat[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Bench for wishbone_ram_slave: one instance with one wait state, one with zero wait states for back-to-back reads.
module tb_wishbone_ram_slave;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int WS_A  = 1;
    localparam int WS_B  = 0;
`ifdef WB_RAM_STALL_RANDOM_EN
    localparam int SLACK = 3;
`else
    localparam int SLACK = 0;
`endif

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we_s, use_b;
    logic [31:0] adr_s, dat_s;
    logic [3:0]  sel_s;
    logic        cyc_a, cyc_b;
    logic        ack_a, ack_b, err_a, err_b;
    logic [31:0] miso_a, miso_b;
    logic        ack, err;
    logic [31:0] miso;

    int   n_chk   = 0;
    int   n_err   = 0;
    int   cyc_cnt = 0;
    exp_t sb[$];
    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last [2];

    assign cyc_a = cyc & ~use_b;
    assign cyc_b = cyc & use_b;
    assign ack   = use_b ? ack_b  : ack_a;
    assign err   = use_b ? err_b  : err_a;
    assign miso  = use_b ? miso_b : miso_a;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wishbone_ram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) u_dut_a (
        .clk(clk), .rst(rst), .wb_cyc(cyc_a), .wb_stb(stb), .wb_we(we_s), .wb_adr(adr_s),
        .wb_sel(sel_s), .wb_dat_mosi(dat_s), .wb_dat_miso(miso_a), .wb_ack(ack_a), .wb_err(err_a)
    );

    wishbone_ram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B)) u_dut_b (
        .clk(clk), .rst(rst), .wb_cyc(cyc_b), .wb_stb(stb), .wb_we(we_s), .wb_adr(adr_s),
        .wb_sel(sel_s), .wb_dat_mosi(dat_s), .wb_dat_miso(miso_b), .wb_ack(ack_b), .wb_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour: decode, byte-lane merge, held read data
    task automatic predict(input bit b, input bit we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
        exp_t e;
        logic bad;
        bad   = (adr[1:0] != 2'b00) || (adr >= 32'(DEPTH * 4));
        e.ack = !bad;
        e.err = bad;
        if (bad) begin
            e.dat = 32'h0;
        end else if (we) begin
            e.dat = last[b];
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) mdl[b][adr[AW+1:2]][8*i +: 8] = dat[8*i +: 8];
            end
        end else begin
            e.dat = mdl[b][adr[AW+1:2]];
        end
        last[b] = e.dat;
        sb.push_back(e);
    endtask

    task automatic check_resp(input string tag, input int lat, input int min_lat);
        exp_t e;
        int   lat_seen;
        chk({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_ack"}, 32'(ack), 32'(e.ack));
            chk({tag, "_err"}, 32'(err), 32'(e.err));
            chk({tag, "_dat"}, miso, e.dat);
            lat_seen = (lat >= min_lat && lat <= min_lat + SLACK) ? min_lat : lat;
            chk({tag, "_lat"}, 32'(lat_seen), 32'(min_lat));
        end
    endtask

    task automatic drive(input bit b, input bit we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        use_b = b; we_s = we; adr_s = adr; sel_s = sel; dat_s = dat;
        cyc = 1'b1; stb = 1'b1;
    endtask

    task automatic xfer(input bit b, input bit we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat);
        int lat;
        @(negedge clk);
        drive(b, we, adr, sel, dat);
        predict(b, we, adr, sel, dat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(ack | err) && lat < 40);
        check_resp(b ? "xfer_b" : "xfer_a", lat, (b ? WS_B : WS_A) + 1);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("resp_pulse", 32'({ack, err}), 32'd0);
    endtask

    // Back-to-back reads on the zero-wait instance, stb held high throughout
    task automatic burst(input int n, input logic [31:0] base);
        int k;
        int guard;
        int t_prev;
        @(negedge clk);
        drive(1'b1, 1'b0, base, 4'h0, 32'h0);
        predict(1'b1, 1'b0, base, 4'h0, 32'h0);
        t_prev = cyc_cnt;
        k      = 0;
        guard  = 0;
        while (k < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (ack | err) begin
                check_resp("burst", cyc_cnt - t_prev, (k == 0) ? WS_B + 1 : WS_B + 2);
                k++;
                t_prev = cyc_cnt;
                if (k < n) begin
                    adr_s = base + 32'(4 * k);
                    predict(1'b1, 1'b0, adr_s, 4'h0, 32'h0);
                end else begin
                    cyc = 1'b0; stb = 1'b0;
                end
            end
        end
        chk("burst_count", 32'(k), 32'(n));
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we_s = 1'b0; use_b = 1'b0;
        adr_s = 32'h0; dat_s = 32'h0; sel_s = 4'h0;
        last[0] = 32'h0; last[1] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_err_a", 32'(err_a), 32'd0);
        chk("rst_dat_a", miso_a, 32'h0);
        chk("rst_ack_b", 32'(ack_b), 32'd0);
        chk("rst_dat_b", miso_b, 32'h0);
        rst = 1'b1;

        xfer(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        xfer(0, 0, 32'h10, 4'hF, 32'h0);

        xfer(0, 1, 32'h20, 4'hF, 32'h11223344);
        xfer(0, 1, 32'h20, 4'b0010, 32'h0000AA00);
        xfer(0, 0, 32'h20, 4'h0, 32'h0);
        chk("merge_word", miso_a, 32'h1122AA44);
        xfer(0, 1, 32'h20, 4'b0000, 32'hFFFFFFFF);
        xfer(0, 1, 32'h04, 4'hF, 32'h0BADF00D);

        xfer(0, 0, 32'h22, 4'hF, 32'h0);
        xfer(0, 0, 32'(DEPTH * 4), 4'hF, 32'h0);
        xfer(0, 1, 32'h22, 4'hF, 32'hFFFFFFFF);
        xfer(0, 1, 32'(DEPTH * 4 + 4), 4'hF, 32'hFFFFFFFF);
        xfer(0, 0, 32'h20, 4'hF, 32'h0);
        xfer(0, 0, 32'h04, 4'hF, 32'h0);
        xfer(0, 1, 32'(DEPTH * 4 - 4), 4'hF, 32'h7E57_0FFC);
        xfer(0, 0, 32'(DEPTH * 4 - 4), 4'hF, 32'h0);

        // Write abandoned by dropping cyc while the slave is waiting
        xfer(0, 1, 32'h30, 4'hF, 32'hCAFE0001);
        @(negedge clk);
        drive(0, 1, 32'h30, 4'hF, 32'hCAFE0002);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_quiet", 32'({ack, err}), 32'd0);
        end
        xfer(0, 0, 32'h30, 4'hF, 32'h0);

        // Reset arriving while a write is pending
        xfer(0, 1, 32'h40, 4'hF, 32'h55AA55AA);
        xfer(0, 0, 32'h40, 4'hF, 32'h0);
        @(negedge clk);
        drive(0, 1, 32'h40, 4'hF, 32'h12345678);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack_a), 32'd0);
        chk("midrst_err", 32'(err_a), 32'd0);
        chk("midrst_dat", miso_a, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        last[0] = 32'h0; last[1] = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        xfer(0, 0, 32'h40, 4'hF, 32'h0);

        for (int i = 0; i < 8; i++) begin
            xfer(1, 1, 32'h80 + 32'(4 * i), 4'hF, 32'hA5000000 + 32'(i * 32'h111));
        end
        burst(8, 32'h80);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
